// File: rtl/conv_dispatch.sv
// Purpose : initiator side of the 3x3 conv engine handshake; builds a pixel window, kicks the engine, buffers the result.
// Latency : 9th pixel accept at cycle N -> calc_enable at N+1 when the buffer is free; result registered on calc_done.
// Backpres: pix_ready drops outside FILL; KICK stalls while the one-entry result buffer is full and not draining.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   pix_valid/pix_data/pix_ready   serial pixel stream, row-major window order
//   filter_load/filter_in    filter coefficients, latched only while filling
//   calc_enable              one-cycle engine start pulse
//   pixels, filter           window and latched filter presented to the engine
//   calc_done, conv          engine completion pulse and result (same cycle)
//   res_valid/res_data/res_ready   one-entry result buffer, ready/valid
//   err                      one-cycle pulse when the engine times out
`timescale 1ns/1ps
module conv_dispatch #(
  parameter int PIX_W   = 4,
  parameter int COEF_W  = 5,
  parameter int CONV_W  = 10,
  parameter int TIMEOUT = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic [PIX_W-1:0]              pix_data,
  output logic                          pix_ready,
  input  logic                          filter_load,
  input  logic [2:0][2:0][COEF_W-1:0]   filter_in,
  output logic                          calc_enable,
  output logic [2:0][2:0][PIX_W-1:0]    pixels,
  output logic [2:0][2:0][COEF_W-1:0]   filter,
  input  logic                          calc_done,
  input  logic [CONV_W-1:0]             conv,
  output logic                          res_valid,
  output logic [CONV_W-1:0]             res_data,
  input  logic                          res_ready,
  output logic                          err
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_KICK = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       pix_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             pix_acc;
  logic             capture;
  logic [1:0]       pix_row;
  logic [1:0]       pix_col;

  // Window slot for the current pixel (pix_cnt/3, pix_cnt%3).
  always_comb begin
    pix_row = 2'd0;
    pix_col = 2'd0;
    case (pix_cnt)
      4'd0: begin pix_row = 2'd0; pix_col = 2'd0; end
      4'd1: begin pix_row = 2'd0; pix_col = 2'd1; end
      4'd2: begin pix_row = 2'd0; pix_col = 2'd2; end
      4'd3: begin pix_row = 2'd1; pix_col = 2'd0; end
      4'd4: begin pix_row = 2'd1; pix_col = 2'd1; end
      4'd5: begin pix_row = 2'd1; pix_col = 2'd2; end
      4'd6: begin pix_row = 2'd2; pix_col = 2'd0; end
      4'd7: begin pix_row = 2'd2; pix_col = 2'd1; end
      4'd8: begin pix_row = 2'd2; pix_col = 2'd2; end
      default: begin pix_row = 2'd0; pix_col = 2'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  // Strobes are gated by rst so nothing leaks out during a reset cycle,
  // even when the reset lands mid-WAIT.
  always_comb begin
    state_nxt   = state;
    pix_ready   = 1'b0;
    calc_enable = 1'b0;
    err         = 1'b0;
    pix_acc     = 1'b0;
    capture     = 1'b0;
    if (!rst) begin
      case (state)
        S_FILL: begin
          pix_ready = 1'b1;
          if (pix_valid) begin
            pix_acc = 1'b1;
            if (pix_cnt == 4'd8) state_nxt = S_KICK;
          end
        end
        S_KICK: begin
          // Start only when the result buffer is empty or drains this cycle,
          // so a capture can never overwrite an unread result.
          if (!res_valid || res_ready) begin
            calc_enable = 1'b1;
            state_nxt   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (calc_done) begin
            capture   = 1'b1;
            state_nxt = S_FILL;
          end else if (tmo_cnt == TMO_LAST) begin
            err       = 1'b1;
            state_nxt = S_FILL;
          end
        end
        default: state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= 4'd0;
      tmo_cnt   <= '0;
      pixels    <= '0;
      filter    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (pix_acc) begin
        pixels[pix_row][pix_col] <= pix_data;
        pix_cnt <= (pix_cnt == 4'd8) ? 4'd0 : pix_cnt + 4'd1;
      end

      // The filter only moves while the engine is idle.
      if (state == S_FILL && filter_load) filter <= filter_in;

      if (calc_enable)          tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;

      // A capture takes priority over a simultaneous drain.
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= conv;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_dispatch.sv
`timescale 1ns/1ps
module tb_conv_dispatch;

  logic                     clk;
  logic                     rst;
  logic                     pix_valid;
  logic [3:0]               pix_data;
  logic                     pix_ready;
  logic                     filter_load;
  logic [2:0][2:0][4:0]     filter_in;
  logic                     calc_enable;
  logic [2:0][2:0][3:0]     pixels;
  logic [2:0][2:0][4:0]     filter;
  logic                     calc_done;
  logic [9:0]               conv;
  logic                     res_valid;
  logic [9:0]               res_data;
  logic                     res_ready;
  logic                     err;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int base;

  conv_dispatch #(.PIX_W(4), .COEF_W(5), .CONV_W(10), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .filter_load(filter_load), .filter_in(filter_in),
    .calc_enable(calc_enable), .pixels(pixels), .filter(filter),
    .calc_done(calc_done), .conv(conv),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (calc_enable) en_cnt++;
    if (err) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pix(input logic [3:0] v);
    pix_valid = 1'b1;
    pix_data  = v;
    tick();
    pix_valid = 1'b0;
    pix_data  = 4'h0;
    settle();
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_data = 4'h0; filter_load = 1'b0;
    filter_in = '0; calc_done = 1'b0; conv = 10'd0; res_ready = 1'b0;
    repeat (2) tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_pixels", pixels, 0);
    chk("rst_filter", filter, 0);
    chk("rst_calc_enable", calc_enable, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    settle();
    chk("rst_pix_ready", pix_ready, 1);

    // 1: unit filter, pixels 1..9, engine answers 45 eleven cycles after start
    filter_in = {9{5'd1}};
    filter_load = 1'b1;
    tick();
    filter_load = 1'b0;
    chk("t1_filter", filter, {9{5'd1}});
    base = en_cnt;
    for (int i = 1; i <= 9; i++) send_pix(4'(i));
    chk("t1_calc_enable", calc_enable, 1);
    chk("t1_kick_pix_ready", pix_ready, 0);
    chk("t1_pixels", pixels, 36'h987654321);
    tick();
    chk("t1_enable_one_cycle", calc_enable, 0);
    repeat (10) tick();
    calc_done = 1'b1; conv = 10'd45;
    settle();
    chk("t1_no_err", err, 0);
    tick();
    calc_done = 1'b0; conv = 10'd0;
    settle();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_data", res_data, 45);
    chk("t1_enable_count", en_cnt - base, 1);
    chk("t1_back_to_fill", pix_ready, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t1_drained", res_valid, 0);

    // 2: stall between pixels 4 and 5
    send_pix(4'hF); send_pix(4'hE); send_pix(4'hD); send_pix(4'hC);
    pix_data = 4'h7;
    repeat (3) tick();
    chk("t2_stall_ready", pix_ready, 1);
    chk("t2_stall_window", pixels, 36'h98765CDEF);
    send_pix(4'h5); send_pix(4'h3); send_pix(4'h2); send_pix(4'h1); send_pix(4'h0);
    chk("t2_enable", calc_enable, 1);
    chk("t2_pixels", pixels, 36'h01235CDEF);
    chk("t2_center", pixels[1][1], 5);
    tick();
    repeat (2) tick();
    calc_done = 1'b1; conv = 10'h155;
    tick();
    calc_done = 1'b0; conv = 10'd0;
    settle();
    chk("t2_res_valid", res_valid, 1);
    chk("t2_res_data", res_data, 10'h155);

    // 3: result not consumed; second window must hold in KICK
    for (int i = 2; i <= 10; i++) send_pix(4'(i));
    repeat (3) tick();
    chk("t3_hold_enable", calc_enable, 0);
    chk("t3_hold_ready", pix_ready, 0);
    chk("t3_hold_res_data", res_data, 10'h155);
    chk("t3_pixels", pixels, 36'hA98765432);
    base = en_cnt;
    res_ready = 1'b1;
    settle();
    chk("t3_enable_on_drain", calc_enable, 1);
    chk("t3_res_still_valid", res_valid, 1);
    tick();
    res_ready = 1'b0;
    settle();
    chk("t3_drained", res_valid, 0);
    chk("t3_single_enable", en_cnt - base, 1);
    chk("t3_in_wait", calc_enable, 0);

    // 4: engine never answers; enable was at cycle K, now at K+1
    base = err_cnt;
    repeat (30) tick();
    chk("t4_no_early_err", err_cnt - base, 0);
    chk("t4_err_low_k31", err, 0);
    tick();
    chk("t4_err_at_timeout", err, 1);
    chk("t4_still_wait", pix_ready, 0);
    tick();
    chk("t4_err_once", err_cnt - base, 1);
    chk("t4_err_cleared", err, 0);
    chk("t4_back_to_fill", pix_ready, 1);
    chk("t4_no_result", res_valid, 0);

    // 5: filter load in WAIT is ignored, in FILL it is taken
    for (int i = 1; i <= 9; i++) send_pix(4'(i));
    chk("t5_enable", calc_enable, 1);
    tick();
    filter_in = {9{5'd3}};
    filter_load = 1'b1;
    tick();
    filter_load = 1'b0;
    chk("t5_wait_load_ignored", filter, {9{5'd1}});
    calc_done = 1'b1; conv = 10'd7;
    tick();
    calc_done = 1'b0; conv = 10'd0;
    chk("t5_res_data", res_data, 7);
    calc_done = 1'b1; conv = 10'd99;
    tick();
    calc_done = 1'b0; conv = 10'd0;
    chk("t5_stray_done_data", res_data, 7);
    chk("t5_stray_done_valid", res_valid, 1);
    filter_in = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    filter_load = 1'b1;
    tick();
    filter_load = 1'b0;
    chk("t5_fill_load", filter, {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // 6: reset mid-WAIT, then a late calc_done
    for (int i = 1; i <= 9; i++) send_pix(4'(i));
    chk("t6_enable", calc_enable, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    calc_done = 1'b1; conv = 10'd300;
    settle();
    chk("t6_pix_ready", pix_ready, 1);
    chk("t6_pixels", pixels, 0);
    chk("t6_filter", filter, 0);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_res_data", res_data, 0);
    chk("t6_calc_enable", calc_enable, 0);
    chk("t6_err", err, 0);
    tick();
    calc_done = 1'b0; conv = 10'd0;
    settle();
    chk("t6_done_ignored_valid", res_valid, 0);
    chk("t6_done_ignored_data", res_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
